// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: owns the program counter, latches the IF/ID register,
// handles stall/branch/halt. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module fetch_pc_ctrl #(
  parameter int                      PC_WIDTH    = 8,
  parameter int                      INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = {PC_WIDTH{1'b0}},
  parameter logic [INSTR_WIDTH-1:0]  HALT_INSTR  = 32'hFFFF_FFFF,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    programCounter,
  output logic [INSTR_WIDTH-1:0] ifIdInstruction,
  output logic [PC_WIDTH-1:0]    ifIdPc,
  output logic [PC_WIDTH-1:0]    ifIdPcPlus1,
  output logic                   ifIdValid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]            fetchCount,
  output logic [31:0]            stallCount,
`endif
  output logic                   halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetchState_t;

  fetchState_t        state;
  logic [PC_WIDTH-1:0] pcPlus1;
  logic                isHalt;
  logic                fetchEvent;
  logic                stallEvent;

  // Next sequential address and event decode shared by the FSM and counters.
  always_comb begin
    pcPlus1    = programCounter + PC_WIDTH'(1);
    isHalt     = (instruction == HALT_INSTR);
    fetchEvent = 1'b0;
    stallEvent = 1'b0;
    if ((state == RUN) && !branchTaken && !stall) begin
      fetchEvent = 1'b1;
    end else begin
      fetchEvent = 1'b0;
    end
    if (stall && !branchTaken) begin
      stallEvent = 1'b1;
    end else begin
      stallEvent = 1'b0;
    end
  end

  // Fetch FSM: PC, IF/ID register and halt flag, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      programCounter  <= RESET_PC;
      ifIdInstruction <= NOP_INSTR;
      ifIdPc          <= {PC_WIDTH{1'b0}};
      ifIdPcPlus1     <= {PC_WIDTH{1'b0}};
      ifIdValid       <= 1'b0;
      halted          <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (branchTaken) begin
            // Redirect wins over stall; the wrong-path word becomes a bubble.
            programCounter  <= branchTarget;
            ifIdInstruction <= NOP_INSTR;
            ifIdValid       <= 1'b0;
          end else if (stall) begin
            programCounter  <= programCounter;
          end else begin
            ifIdInstruction <= instruction;
            ifIdPc          <= programCounter;
            ifIdPcPlus1     <= pcPlus1;
            ifIdValid       <= 1'b1;
            if (isHalt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              programCounter <= pcPlus1;
            end
          end
        end
        HALT: begin
          if (branchTaken) begin
            // An older branch cancels a speculatively fetched halt.
            programCounter  <= branchTarget;
            ifIdInstruction <= NOP_INSTR;
            ifIdValid       <= 1'b0;
            state           <= RUN;
            halted          <= 1'b0;
          end else if (stall) begin
            programCounter  <= programCounter;
          end else begin
            ifIdInstruction <= NOP_INSTR;
            ifIdValid       <= 1'b0;
          end
        end
        default: begin
          state           <= RUN;
          programCounter  <= RESET_PC;
          ifIdInstruction <= NOP_INSTR;
          ifIdValid       <= 1'b0;
          halted          <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating fetch and stall event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCount <= 32'd0;
      stallCount <= 32'd0;
    end else begin
      if (fetchEvent && (fetchCount != 32'hFFFF_FFFF)) begin
        fetchCount <= fetchCount + 32'd1;
      end else begin
        fetchCount <= fetchCount;
      end
      if (stallEvent && (stallCount != 32'hFFFF_FFFF)) begin
        stallCount <= stallCount + 32'd1;
      end else begin
        stallCount <= stallCount;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: stimulus pushes expected IF/ID state, a monitor
// pops and compares after every rising edge. A second instance covers PC wrap.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] A = 32'hA0A0_0001;
  localparam logic [31:0] B = 32'hB0B0_0002;
  localparam logic [31:0] C = 32'hC0C0_0003;
  localparam logic [31:0] D = 32'hD0D0_0004;
  localparam logic [31:0] E = 32'hE0E0_0005;
  localparam logic [31:0] F = 32'hF0F0_0006;
  localparam logic [31:0] G = 32'h1717_0007;
  localparam logic [31:0] I = 32'h1818_0008;
  localparam logic [31:0] J = 32'h4040_0040;
  localparam logic [31:0] X = 32'h5E5E_00FE;
  localparam logic [31:0] Y = 32'h5F5F_00FF;
  localparam logic [31:0] HLT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    string       name;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [7:0]  ifPc;
    logic [7:0]  plus1;
    logic        valid;
    logic        halted;
  } exp_t;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ifPc;
    logic [7:0] plus1;
  } wrapExp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [7:0]  branchTarget = 8'h00;
  logic [31:0] instruction, instructionW;
  logic [7:0]  programCounter, ifIdPc, ifIdPcPlus1;
  logic [31:0] ifIdInstruction;
  logic        ifIdValid, halted;
  logic [7:0]  programCounterW, ifIdPcW, ifIdPcPlus1W;
  logic [31:0] ifIdInstructionW;
  logic        ifIdValidW, haltedW;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCount, stallCount, fetchCountW, stallCountW;
`endif

  logic [31:0] mem [256];
  exp_t        expQ[$];
  wrapExp_t    wrapQ[$];
  exp_t        monE;
  wrapExp_t    monW;
  int          checks = 0;
  int          passCnt = 0;

  assign instruction  = mem[programCounter];
  assign instructionW = mem[programCounterW];

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .instruction(instruction),
    .programCounter(programCounter), .ifIdInstruction(ifIdInstruction),
    .ifIdPc(ifIdPc), .ifIdPcPlus1(ifIdPcPlus1), .ifIdValid(ifIdValid),
`ifdef FETCH_PERF_CNT_EN
    .fetchCount(fetchCount), .stallCount(stallCount),
`endif
    .halted(halted)
  );

  fetch_pc_ctrl #(.RESET_PC(8'hFE)) dutWrap (
    .clk(clk), .rst(rst), .stall(1'b0), .branchTaken(1'b0),
    .branchTarget(8'h00), .instruction(instructionW),
    .programCounter(programCounterW), .ifIdInstruction(ifIdInstructionW),
    .ifIdPc(ifIdPcW), .ifIdPcPlus1(ifIdPcPlus1W), .ifIdValid(ifIdValidW),
`ifdef FETCH_PERF_CNT_EN
    .fetchCount(fetchCountW), .stallCount(stallCountW),
`endif
    .halted(haltedW)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a falling edge: apply inputs, queue the state expected after the next rise.
  task automatic step(input string nm, input logic st, input logic br, input logic [7:0] tgt,
                      input logic [7:0] ePc, input logic [31:0] eIn, input logic [7:0] eIfPc,
                      input logic [7:0] ePlus1, input logic eV, input logic eH);
    exp_t e;
    stall = st;
    branchTaken = br;
    branchTarget = tgt;
    e.name = nm; e.pc = ePc; e.instr = eIn; e.ifPc = eIfPc;
    e.plus1 = ePlus1; e.valid = eV; e.halted = eH;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic pushWrap(input logic [7:0] p, input logic [7:0] ip, input logic [7:0] p1);
    wrapExp_t w;
    w.pc = p; w.ifPc = ip; w.plus1 = p1;
    wrapQ.push_back(w);
  endtask

  task automatic chkReset(input string nm);
    chk({nm, ".pc"}, {24'd0, programCounter}, 32'd0);
    chk({nm, ".instr"}, ifIdInstruction, NOP);
    chk({nm, ".ifPc"}, {24'd0, ifIdPc}, 32'd0);
    chk({nm, ".plus1"}, {24'd0, ifIdPcPlus1}, 32'd0);
    chk({nm, ".valid"}, {31'd0, ifIdValid}, 32'd0);
    chk({nm, ".halted"}, {31'd0, halted}, 32'd0);
    chk({nm, ".wrapPc"}, {24'd0, programCounterW}, 32'h0000_00FE);
  endtask

  // Monitor: compare DUT state against the oldest queued expectation after each rise.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk({monE.name, ".pc"}, {24'd0, programCounter}, {24'd0, monE.pc});
      chk({monE.name, ".instr"}, ifIdInstruction, monE.instr);
      chk({monE.name, ".ifPc"}, {24'd0, ifIdPc}, {24'd0, monE.ifPc});
      chk({monE.name, ".plus1"}, {24'd0, ifIdPcPlus1}, {24'd0, monE.plus1});
      chk({monE.name, ".valid"}, {31'd0, ifIdValid}, {31'd0, monE.valid});
      chk({monE.name, ".halted"}, {31'd0, halted}, {31'd0, monE.halted});
    end
    if (wrapQ.size() > 0) begin
      monW = wrapQ.pop_front();
      chk("wrap.pc", {24'd0, programCounterW}, {24'd0, monW.pc});
      chk("wrap.ifPc", {24'd0, ifIdPcW}, {24'd0, monW.ifPc});
      chk("wrap.plus1", {24'd0, ifIdPcPlus1W}, {24'd0, monW.plus1});
    end
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0000_0000;
    mem[0] = A; mem[1] = B; mem[2] = C; mem[3] = D; mem[4] = E;
    mem[5] = F; mem[6] = G; mem[8] = I; mem[9] = HLT;
    mem[8'h40] = J; mem[8'hFE] = X; mem[8'hFF] = Y;

    repeat (2) @(negedge clk);
    chkReset("reset");
    rst = 1'b0;

    // Free run: 0..4
    pushWrap(8'hFF, 8'hFE, 8'hFF);
    step("run0", 1'b0, 1'b0, 8'h00, 8'h01, A, 8'h00, 8'h01, 1'b1, 1'b0);
    pushWrap(8'h00, 8'hFF, 8'h00);
    step("run1", 1'b0, 1'b0, 8'h00, 8'h02, B, 8'h01, 8'h02, 1'b1, 1'b0);
    step("run2", 1'b0, 1'b0, 8'h00, 8'h03, C, 8'h02, 8'h03, 1'b1, 1'b0);
    step("run3", 1'b0, 1'b0, 8'h00, 8'h04, D, 8'h03, 8'h04, 1'b1, 1'b0);
    step("run4", 1'b0, 1'b0, 8'h00, 8'h05, E, 8'h04, 8'h05, 1'b1, 1'b0);
    // Stall three cycles at PC=5
    for (int s = 0; s < 3; s++)
      step("stall5", 1'b1, 1'b0, 8'h00, 8'h05, E, 8'h04, 8'h05, 1'b1, 1'b0);
    step("resume5", 1'b0, 1'b0, 8'h00, 8'h06, F, 8'h05, 8'h06, 1'b1, 1'b0);
    step("run6", 1'b0, 1'b0, 8'h00, 8'h07, G, 8'h06, 8'h07, 1'b1, 1'b0);
    // Branch overriding stall at PC=7
    step("brStall", 1'b1, 1'b1, 8'h40, 8'h40, NOP, 8'h06, 8'h07, 1'b0, 1'b0);
    step("run40", 1'b0, 1'b0, 8'h00, 8'h41, J, 8'h40, 8'h41, 1'b1, 1'b0);
    step("br8", 1'b0, 1'b1, 8'h08, 8'h08, NOP, 8'h40, 8'h41, 1'b0, 1'b0);
    step("run8", 1'b0, 1'b0, 8'h00, 8'h09, I, 8'h08, 8'h09, 1'b1, 1'b0);
    // Halt at 9: delivered once, then bubbles
    step("halt9", 1'b0, 1'b0, 8'h00, 8'h09, HLT, 8'h09, 8'h0A, 1'b1, 1'b1);
    step("haltBub", 1'b0, 1'b0, 8'h00, 8'h09, NOP, 8'h09, 8'h0A, 1'b0, 1'b1);
    step("haltStall", 1'b1, 1'b0, 8'h00, 8'h09, NOP, 8'h09, 8'h0A, 1'b0, 1'b1);
    step("haltBr2", 1'b0, 1'b1, 8'h02, 8'h02, NOP, 8'h09, 8'h0A, 1'b0, 1'b0);
    step("run2b", 1'b0, 1'b0, 8'h00, 8'h03, C, 8'h02, 8'h03, 1'b1, 1'b0);
    // Halt word seen under stall is not latched
    step("br9", 1'b0, 1'b1, 8'h09, 8'h09, NOP, 8'h02, 8'h03, 1'b0, 1'b0);
    step("stallHalt", 1'b1, 1'b0, 8'h00, 8'h09, NOP, 8'h02, 8'h03, 1'b0, 1'b0);
    step("halt9b", 1'b0, 1'b0, 8'h00, 8'h09, HLT, 8'h09, 8'h0A, 1'b1, 1'b1);
    stall = 1'b0;

    // Async reset mid-cycle while halted
    #2 rst = 1'b1;
    #1 chkReset("asyncRst");
    @(negedge clk);
    rst = 1'b0;

    // Four fetches and two stalls after reset
    step("pc0", 1'b0, 1'b0, 8'h00, 8'h01, A, 8'h00, 8'h01, 1'b1, 1'b0);
    step("pc1", 1'b0, 1'b0, 8'h00, 8'h02, B, 8'h01, 8'h02, 1'b1, 1'b0);
    step("st2a", 1'b1, 1'b0, 8'h00, 8'h02, B, 8'h01, 8'h02, 1'b1, 1'b0);
    step("st2b", 1'b1, 1'b0, 8'h00, 8'h02, B, 8'h01, 8'h02, 1'b1, 1'b0);
    step("pc2", 1'b0, 1'b0, 8'h00, 8'h03, C, 8'h02, 8'h03, 1'b1, 1'b0);
    step("pc3", 1'b0, 1'b0, 8'h00, 8'h04, D, 8'h03, 8'h04, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("fetchCount", fetchCount, 32'd4);
    chk("stallCount", stallCount, 32'd2);
`endif

    chk("queueDrained", expQ.size() + wrapQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCnt, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Upstream and downstream neighbour of the fetch instruction memory.
- Owns the word-addressed program counter and drives `programCounter` into the instruction memory.
- Takes back the combinational `instruction` and latches it into the IF/ID pipeline register for decode.
- Handles stall, branch redirect and flush, and halt detection with a small state machine.

Parameters:
- PC_WIDTH, 8, PC width in bits; addresses 2^PC_WIDTH instruction words.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_INSTR, 32'hFFFFFFFF, encoding that halts fetch.
- NOP_INSTR, 32'h00000000, encoding inserted as a bubble.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit request to hold PC and IF/ID.
- branchTaken  input  1  redirect request from a later stage.
- branchTarget  input  PC_WIDTH  redirect word address.
- instruction  input  INSTR_WIDTH  instruction memory read data; combinational from `programCounter`.
- programCounter  output  PC_WIDTH  current fetch address to instruction memory.
- ifIdInstruction  output  INSTR_WIDTH  latched instruction.
- ifIdPc  output  PC_WIDTH  address of the latched instruction.
- ifIdPcPlus1  output  PC_WIDTH  ifIdPc+1, modulo 2^PC_WIDTH.
- ifIdValid  output  1  IF/ID holds a real instruction.
- halted  output  1  high while in state HALT.

Behaviour:
- Reset (async, takes effect immediately on rst=1):
  - programCounter=RESET_PC.
  - ifIdInstruction=NOP_INSTR, ifIdPc=0, ifIdPcPlus1=0, ifIdValid=0.
  - State RUN, halted=0.
- All other updates occur on the rising edge of clk. rst asserted mid-operation discards everything in flight.
- A fetched instruction appears on the IF/ID outputs 1 cycle after its address is presented.
- Priority at each edge: branchTaken > stall > normal advance.
- State RUN:
  - branchTaken=1: PC<=branchTarget; IF/ID<=bubble (instruction=NOP_INSTR, valid=0, ifIdPc/ifIdPcPlus1 hold); stay RUN. Overrides stall in the same cycle.
  - stall=1: PC and all IF/ID outputs hold.
  - Otherwise: ifIdInstruction<=instruction, ifIdPc<=PC, ifIdPcPlus1<=PC+1, ifIdValid<=1.
    - If instruction==HALT_INSTR: PC holds, state<=HALT.
    - Else: PC<=PC+1.
- State HALT:
  - PC holds.
  - stall=0 and branchTaken=0: IF/ID<=bubble, so the halt instruction is delivered exactly once.
  - stall=1: IF/ID holds.
  - branchTaken=1: PC<=branchTarget, IF/ID<=bubble, state<=RUN. This makes a speculatively fetched halt cancellable by an older branch.
  - Only rst or branchTaken leaves HALT.
- Arithmetic:
  - PC+1 wraps modulo 2^PC_WIDTH, so PC 8'hFF advances to 8'h00 with no flag.
  - branchTarget is used unmodified.
- A HALT_INSTR fetched while stall=1 is not latched and does not change state.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetchCount[31:0] and stallCount[31:0], both reset to 0.
  - fetchCount increments on every edge where IF/ID loads with ifIdValid<=1.
  - stallCount increments on every edge with stall=1 and branchTaken=0.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then free-run with memory words 0..3 = A,B,C,D, stall=0: programCounter 0,1,2,3 on successive cycles; one cycle later ifIdInstruction=A,B,C with ifIdPc=0,1,2, ifIdPcPlus1=1,2,3, ifIdValid=1.
- stall=1 for 3 cycles at PC=5: programCounter stays 5 and IF/ID outputs unchanged for 3 cycles; resumes at 6 after stall drops.
- branchTaken=1, branchTarget=8'h40 while stall=1 at PC=7: next cycle programCounter=8'h40 and ifIdValid=0, ifIdInstruction=0; the following cycle ifIdPc=8'h40.
- HALT_INSTR at address 9: ifIdInstruction=FFFFFFFF with ifIdValid=1 for one cycle, halted=1, programCounter stays 9, next IF/ID is a bubble. branchTaken to 8'h02 then returns to RUN, halted=0, programCounter=2.
- PC wrap, RESET_PC=8'hFE: programCounter FE,FF,00; ifIdPcPlus1 for address FF equals 00.
- rst pulsed asynchronously mid-cycle during HALT: outputs return to reset values immediately without a clock edge. With FETCH_PERF_CNT_EN, after 4 fetches and 2 stalls, fetchCount=4 and stallCount=2.
